// File: rtl/controlador_display_7_segmentos.sv
// controlador_display_7_segmentos: time-multiplexed driver for a 4-digit common-anode 7-segment display
module controlador_display_7_segmentos #(
    parameter int REFRESH_DIV = 100000,
    parameter int CNT_W       = 24
) (
    input  logic       i_Reloj,
    input  logic       i_Reset,
    input  logic [3:0] i_Datos_0,
    input  logic [3:0] i_Datos_1,
    input  logic [3:0] i_Datos_2,
    input  logic [3:0] i_Datos_3,
    output logic [6:0] o_Segmentos,
    output logic [3:0] o_Anodo_4_Bits
);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [6:0]       seg_q, seg_d;
    logic [3:0]       an_q, an_d;
    logic [3:0]       nib;
    logic             wrap;

    // Prescaler: hold each digit for REFRESH_DIV cycles, then step to the next one
    always_comb begin
        wrap  = cnt_q == CNT_W'(REFRESH_DIV - 1);
        cnt_d = wrap ? '0 : cnt_q + 1'b1;
        idx_d = wrap ? idx_q + 2'd1 : idx_q;
        an_d  = ~(4'b0001 << idx_q);
        nib   = idx_q == 2'd0 ? i_Datos_0 :
                idx_q == 2'd1 ? i_Datos_1 :
                idx_q == 2'd2 ? i_Datos_2 : i_Datos_3;
    end

    // Hex-to-segment decode, active-low {g,f,e,d,c,b,a}
    always_comb begin
        seg_d = 7'b1111111;
        case (nib)
            4'h0: seg_d = 7'b1000000;
            4'h1: seg_d = 7'b1111001;
            4'h2: seg_d = 7'b0100100;
            4'h3: seg_d = 7'b0110000;
            4'h4: seg_d = 7'b0011001;
            4'h5: seg_d = 7'b0010010;
            4'h6: seg_d = 7'b0000010;
            4'h7: seg_d = 7'b1111000;
            4'h8: seg_d = 7'b0000000;
            4'h9: seg_d = 7'b0010000;
            4'hA: seg_d = 7'b0001000;
            4'hB: seg_d = 7'b0000011;
            4'hC: seg_d = 7'b1000110;
            4'hD: seg_d = 7'b0100001;
            4'hE: seg_d = 7'b0000110;
            4'hF: seg_d = 7'b0001110;
            default: seg_d = 7'b1111111;
        endcase
    end

    // State and registered outputs; reset blanks the display and restarts at digit 0
    always_ff @(posedge i_Reloj) begin
        if (i_Reset) begin
            cnt_q <= '0;
            idx_q <= '0;
            an_q  <= 4'b1111;
            seg_q <= 7'b1111111;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            an_q  <= an_d;
            seg_q <= seg_d;
        end
    end

    assign o_Segmentos    = seg_q;
    assign o_Anodo_4_Bits = an_q;
endmodule

// File: tb/tb_controlador_display_7_segmentos.sv
// tb_controlador_display_7_segmentos: scoreboard bench for the 7-segment display driver
module tb_controlador_display_7_segmentos;
    typedef struct packed {
        logic       which;
        logic [3:0] an;
        logic [6:0] seg;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] d [4];
    logic [6:0] seg_a, seg_b;
    logic [3:0] an_a, an_b;
    exp_t       exp_q [$];
    string      name_q [$];
    int         tests = 0;
    int         fails = 0;

    logic [6:0] tbl [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    controlador_display_7_segmentos #(.REFRESH_DIV(4), .CNT_W(24)) dut_a (
        .i_Reloj(clk), .i_Reset(rst),
        .i_Datos_0(d[0]), .i_Datos_1(d[1]), .i_Datos_2(d[2]), .i_Datos_3(d[3]),
        .o_Segmentos(seg_a), .o_Anodo_4_Bits(an_a)
    );

    controlador_display_7_segmentos #(.REFRESH_DIV(1), .CNT_W(4)) dut_b (
        .i_Reloj(clk), .i_Reset(rst),
        .i_Datos_0(d[0]), .i_Datos_1(d[1]), .i_Datos_2(d[2]), .i_Datos_3(d[3]),
        .o_Segmentos(seg_b), .o_Anodo_4_Bits(an_b)
    );

    always #5 clk = ~clk;

    // Monitor: compare every expectation queued for the edge just taken
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            automatic exp_t  e  = exp_q.pop_front();
            automatic string nm = name_q.pop_front();
            automatic logic [10:0] got = e.which ? {an_b, seg_b} : {an_a, seg_a};
            tests++;
            if (got !== {e.an, e.seg}) begin
                fails++;
                $display("FAIL %s dut_%s: got an=%b seg=%b, expected an=%b seg=%b",
                         nm, e.which ? "b" : "a", got[10:7], got[6:0], e.an, e.seg);
            end
        end
    end

    task automatic step(input logic ca, input logic [3:0] aa, input logic [6:0] sa,
                        input logic cb, input logic [3:0] ab, input logic [6:0] sb,
                        input string nm);
        @(posedge clk);
        if (ca) begin
            exp_q.push_back('{1'b0, aa, sa});
            name_q.push_back(nm);
        end
        if (cb) begin
            exp_q.push_back('{1'b1, ab, sb});
            name_q.push_back(nm);
        end
        @(negedge clk);
    endtask

    task automatic digit_a(input int dd, input int n, input string nm);
        for (int k = 0; k < n; k++)
            step(1'b1, ~(4'b0001 << dd), tbl[d[dd]], 1'b0, 4'h0, 7'h0, nm);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        d[0] = 4'd1; d[1] = 4'd2; d[2] = 4'd3; d[3] = 4'd4;
        rst = 1'b1;
        for (int k = 0; k < 2; k++)
            step(1'b1, 4'b1111, 7'b1111111, 1'b1, 4'b1111, 7'b1111111, "reset");
        rst = 1'b0;
        step(1'b1, 4'b1110, 7'b1111001, 1'b0, 4'h0, 7'h0, "scan_d0_first");
        digit_a(0, 3, "scan_d0");
        for (int k = 0; k < 4; k++) step(1'b1, 4'b1101, 7'b0100100, 1'b0, 4'h0, 7'h0, "scan_d1");
        for (int k = 0; k < 4; k++) step(1'b1, 4'b1011, 7'b0110000, 1'b0, 4'h0, 7'h0, "scan_d2");
        for (int k = 0; k < 4; k++) step(1'b1, 4'b0111, 7'b0011001, 1'b0, 4'h0, 7'h0, "scan_d3");
        for (int v = 1; v <= 16; v++) begin
            d[0] = 4'(v % 16);
            digit_a(0, 4, "sweep_d0");
            for (int dd = 1; dd < 4; dd++) digit_a(dd, 4, "sweep_other");
        end
        digit_a(0, 4, "pre_mid_d0");
        digit_a(1, 4, "pre_mid_d1");
        step(1'b1, 4'b1011, 7'b0110000, 1'b0, 4'h0, 7'h0, "mid_d2");
        rst = 1'b1;
        step(1'b1, 4'b1111, 7'b1111111, 1'b0, 4'h0, 7'h0, "mid_reset");
        rst = 1'b0;
        step(1'b1, 4'b1110, 7'b1000000, 1'b0, 4'h0, 7'h0, "restart_d0");
        digit_a(0, 3, "restart_d0_rest");
        digit_a(1, 2, "live_d1");
        d[3] = 4'd8;
        digit_a(1, 2, "live_d1");
        digit_a(2, 4, "live_d2");
        for (int k = 0; k < 4; k++) step(1'b1, 4'b0111, 7'b0000000, 1'b0, 4'h0, 7'h0, "live_d3");
        d[0] = 4'd1; d[1] = 4'd2; d[2] = 4'd3; d[3] = 4'd4;
        rst = 1'b1;
        step(1'b1, 4'b1111, 7'b1111111, 1'b1, 4'b1111, 7'b1111111, "reset2");
        rst = 1'b0;
        step(1'b1, 4'b1110, 7'b1111001, 1'b1, 4'b1110, 7'b1111001, "div1_e1");
        step(1'b1, 4'b1110, 7'b1111001, 1'b1, 4'b1101, 7'b0100100, "div1_e2");
        step(1'b1, 4'b1110, 7'b1111001, 1'b1, 4'b1011, 7'b0110000, "div1_e3");
        step(1'b1, 4'b1110, 7'b1111001, 1'b1, 4'b0111, 7'b0011001, "div1_e4");
        step(1'b1, 4'b1101, 7'b0100100, 1'b1, 4'b1110, 7'b1111001, "div1_e5");
        @(negedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/controlador_display_7_segmentos.md
Name:
controlador_display_7_segmentos

Overview:
- Time-multiplexed driver for a 4-digit common-anode 7-segment display.
- Takes four 4-bit hex nibbles and a free-running clock.
- Cycles through the digits at a parameterised refresh rate, driving one anode at a time with the matching decoded segment pattern.
- Sits between datapath registers and the board display pins; both output buses are active-low.

Parameters:
- REFRESH_DIV, default 100000: clock cycles each digit stays lit. Legal range is 1 to 2^24; simulation benches override it to a small value such as 4.
- CNT_W, default 24: width of the prescaler counter. Must satisfy 2^CNT_W >= REFRESH_DIV.

Ports:
- i_Reloj, input, 1: system clock; all state updates on its rising edge.
- i_Reset, input, 1: synchronous active-high reset.
- i_Datos_0, input, 4: hex value for digit 0 (rightmost, anode bit 0).
- i_Datos_1, input, 4: hex value for digit 1.
- i_Datos_2, input, 4: hex value for digit 2.
- i_Datos_3, input, 4: hex value for digit 3 (leftmost, anode bit 3).
- o_Segmentos, output, 7: segment drive, active-low, bit order {g,f,e,d,c,b,a} (bit 0 = a).
- o_Anodo_4_Bits, output, 4: digit enables, active-low; exactly one bit is 0 outside reset.

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - Reset is synchronous and active-high, sampled on the rising edge of i_Reloj.
- State:
  - Prescaler counter cnt, CNT_W bits.
  - Digit index idx, 2 bits.
  - Registered outputs o_Segmentos and o_Anodo_4_Bits.
- Reset (i_Reset=1 at a rising edge):
  - cnt=0 and idx=0.
  - o_Anodo_4_Bits=4'b1111 (all digits off).
  - o_Segmentos=7'b1111111 (all segments off).
  - Reset asserted mid-scan has the same effect: the next edge with i_Reset=0 restarts the scan at digit 0.
- Prescaler, on each edge with i_Reset=0:
  - If cnt==REFRESH_DIV-1: cnt<=0 and idx<=idx+1, wrapping 3->0.
  - Otherwise cnt<=cnt+1 and idx holds.
  - With REFRESH_DIV=1, idx advances on every edge.
- Outputs, on each edge with i_Reset=0, using the pre-edge idx:
  - o_Anodo_4_Bits <= ~(4'b0001 << idx).
  - o_Segmentos <= decode(i_Datos_idx).
  - Outputs therefore lag the index change by one cycle.
- Timing consequences:
  - The first edge after reset release shows digit 0.
  - Each digit is displayed for exactly REFRESH_DIV consecutive cycles.
  - Scan order is 0,1,2,3,0,...
  - Full frame period is 4*REFRESH_DIV cycles.
- Data inputs are not latched. A change on any i_Datos_n appears at the next edge where that digit is selected, and no extra latency is added.
- Decode table (active-low {g..a}):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Other output rules:
  - The decimal point is not driven by this block.
  - No X is allowed on any output after the first reset edge.
  - The anode bus is never all-zero and never has two zeros.

Test Plan:
1. Reset check, REFRESH_DIV=4, data 1,2,3,4: hold i_Reset=1 for 2 edges -> o_Anodo_4_Bits=1111 and o_Segmentos=1111111.
2. Scan order: release reset, same data -> edges 1-4 show anode 1110 / seg 1111001; edges 5-8 show 1101 / 0100100; edges 9-12 show 1011 / 0110000; edges 13-16 show 0111 / 0011001; edge 17 shows 1110 / 1111001 again.
3. Full decode sweep: drive i_Datos_0 with 0..F, holding each value for one frame -> every digit-0 slot shows the table value (e.g. A=0001000, F=0001110).
4. Reset mid-scan: assert i_Reset for one edge while digit 2 is lit -> outputs go 1111/1111111; the next edge shows digit 0 (1110).
5. Live data update: change i_Datos_3 from 4 to 8 while digit 1 is lit -> the next digit-3 slot shows 0111 / 0000000.
6. REFRESH_DIV=1: anodes rotate 1110, 1101, 1011, 0111 on consecutive edges, with segments matching each digit.
